noc_sink_checker: RTL and testbench
===================================

Name: noc_sink_checker

Overview:
- Receive-side counterpart of the NoC random traffic generator PE.
- Sits at one mesh node (xcord, ycord) and consumes packets ejected by the local router.
- Applies a programmable backpressure pattern on o_ready.
- Checks every accepted flit for correct destination, a legal source and per-source sequence order.
- Counts packets, flags errors and asserts done once the expected packet count has arrived.

Parameters:
- xcord, 0, this node's X coordinate.
- ycord, 0, this node's Y coordinate.
- data_width, 240, payload width; payload carries the sender's sequence counter.
- X, 4, mesh columns.
- Y, 4, mesh rows.
- dest_x, 2, width of destination X field.
- dest_y, 2, width of destination Y field.
- source_x, 8, width of source X field.
- source_y, 8, width of source Y field.
- total_width, dest_x+dest_y+source_x+source_y+data_width, flit width.
- expected_pckts, 3, packets this node must receive before done.
- ready_rate, 1, backpressure period; 1 = always ready; N>1 = o_ready low 1 cycle in every N.
- seq_width, 32, number of low payload bits compared as sequence number; must be <= data_width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- i_data  in  total_width  flit, LSB first: {payload, src_y, src_x, dst_y, dst_x}.
- i_valid  in  1  flit valid from router.
- o_ready  out  1  sink can accept this cycle.
- o_rx_count  out  32  packets accepted since reset.
- o_err_dest  out  1  sticky: flit with dst != (xcord, ycord).
- o_err_src  out  1  sticky: src_x >= X or src_y >= Y.
- o_err_order  out  1  sticky: non-increasing sequence from the same source.
- o_err_over  out  1  sticky: flit accepted after done.
- o_err_count  out  16  total error events, saturating at 16'hFFFF.
- o_done  out  1  o_rx_count == expected_pckts.

Behaviour:
- Reset values (rstn low at posedge clk):
  - o_rx_count 0, all sticky flags 0, o_err_count 0, o_done 0.
  - Ready phase counter 0.
  - All per-source seen bits 0; last_seq contents are don't-care.
- Handshake: accept = i_valid & o_ready, sampled at posedge.
  - i_data is only meaningful when accept is high.
  - There is no i_valid-to-o_ready dependency; o_ready is a pure function of the phase counter.
- Backpressure:
  - Phase counter counts 0..ready_rate-1 and wraps, free-running.
  - o_ready is registered; it is 0 when the phase counter is ready_rate-1 and ready_rate > 1, else 1.
  - With ready_rate = 1, o_ready stays 1 from the first cycle after reset.
- Field decode: slice the fields from i_data; seq = payload[seq_width-1:0].
- Source index = src_y*X + src_x. This is computed only when the source is legal; otherwise no scoreboard access.
- Checks, all evaluated on the same accept cycle:
  - dest error if dst_x != xcord or dst_y != ycord.
  - src error if src_x >= X or src_y >= Y.
  - order error if the source is legal, seen[idx] = 1 and seq <= last_seq[idx].
  - over error if o_done is already 1.
- Scoreboard update on accept with a legal source: last_seq[idx] <= seq, seen[idx] <= 1. This update happens even if other errors fired.
- Latency: all outputs are registered and reflect an accept one cycle after the accepting edge.
- o_rx_count increments on every accept, including erroneous ones, and saturates at all-ones.
- o_err_count adds the number of error types raised on that accept (0..4), saturating.
- Each sticky flag sets on its event and clears only on reset.
- o_done is combinationally equal to (o_rx_count == expected_pckts). It drops again if an overflow accept pushes the count past expected_pckts; o_err_over stays set.
- Sequence wrap: a wrap from all-ones to 0 within seq_width is reported as an order error. This is intentional; benches keep traffic below 2^seq_width per source.
- Back-to-back accepts from the same source on consecutive cycles must compare against the just-written last_seq. This requires write-to-read forwarding in the scoreboard.
- Reset mid-stream: all counters, flags and seen bits clear on that edge; a flit presented on the reset edge is discarded.

Decomposition:
- Shared package noc_pkt_pkg holds:
  - Field offset constants (DST_X_LSB, DST_Y_LSB, SRC_X_LSB, SRC_Y_LSB, PAYLOAD_LSB) derived from the width parameters.
  - A source-index function shared with the generator and other testbench PEs.
- One sub-module, noc_seq_scoreboard:
  - X*Y entries of {seen, last_seq[seq_width-1:0]}.
  - Single write port, same-cycle read with write forwarding.
  - Synchronous clear of the seen bits on rstn low.

Test Plan:
- ready_rate=1, node (1,2), three flits from src (0,0) with seq 0,1,2 -> o_ready constantly 1; o_rx_count 1,2,3 one cycle after each accept; o_done=1 after the third; no error flags.
- ready_rate=4, i_valid held high for 8 cycles -> o_ready low on cycles 3 and 7 after the first ready cycle; exactly 6 accepts counted.
- Flit to (0,0) delivered at node (1,2) -> o_err_dest=1, o_err_count=1, o_rx_count=1.
- Src (3,1) seq 5, then the same src seq 5 on the next cycle (forwarding path), then seq 4 -> o_err_order=1, o_err_count=2; src (2,1) seq 0 in between raises no error.
- Src_x=4 with X=4 -> o_err_src=1, scoreboard untouched; a later legal flit from (0,1) seq 0 raises no order error.
- expected_pckts=3, send 4 legal flits -> o_done high after the third, o_err_over=1 and o_done low after the fourth; then assert rstn low for one cycle -> all outputs return to 0.

Source files
------------

// File: rtl/noc_pkt_pkg.sv
// Shared NoC flit layout: default field widths, field offsets and the source-index mapping
// used by the generator, the sink checker and the testbench PEs.
package noc_pkt_pkg;

  localparam int DEST_X_W   = 2;
  localparam int DEST_Y_W   = 2;
  localparam int SOURCE_X_W = 8;
  localparam int SOURCE_Y_W = 8;
  localparam int DATA_W     = 240;

  // Flit is packed LSB first: {payload, src_y, src_x, dst_y, dst_x}
  localparam int DST_X_LSB   = 0;
  localparam int DST_Y_LSB   = DST_X_LSB + DEST_X_W;
  localparam int SRC_X_LSB   = DST_Y_LSB + DEST_Y_W;
  localparam int SRC_Y_LSB   = SRC_X_LSB + SOURCE_X_W;
  localparam int PAYLOAD_LSB = SRC_Y_LSB + SOURCE_Y_W;
  localparam int TOTAL_W     = PAYLOAD_LSB + DATA_W;

  function automatic int unsigned src_index(input int unsigned sx, input int unsigned sy,
                                            input int unsigned cols);
    return sy * cols + sx;
  endfunction

endpackage

// File: rtl/noc_seq_scoreboard.sv
// Per-source {seen, last_seq} table. Writes are staged one cycle in a pending slot and
// forwarded to the read port so back-to-back flits from one source see the newest sequence.
module noc_seq_scoreboard #(
  parameter int entries   = 16,
  parameter int idx_w     = 4,
  parameter int seq_width = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [idx_w-1:0]     rd_idx,
  output logic                 rd_seen,
  output logic [seq_width-1:0] rd_seq,
  input  logic                 wr_en,
  input  logic [idx_w-1:0]     wr_idx,
  input  logic [seq_width-1:0] wr_seq
);

  logic [entries-1:0]   seen;
  logic [seq_width-1:0] last_seq [entries];
  logic                 pend_vld;
  logic [idx_w-1:0]     pend_idx;
  logic [seq_width-1:0] pend_seq;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_vld <= 1'b0;
      seen     <= '0;
    end else begin
      pend_vld <= wr_en;
      if (pend_vld) seen[pend_idx] <= 1'b1;
    end
  end

  // NOTE: the sequence array and pending data carry no reset; seen/pend_vld qualify them.
  always_ff @(posedge clk) begin
    pend_idx <= wr_idx;
    pend_seq <= wr_seq;
    if (pend_vld) last_seq[pend_idx] <= pend_seq;
  end

  // NOTE: defaults first in always_comb so no path can infer a latch.
  always_comb begin
    rd_seen = seen[rd_idx];
    rd_seq  = last_seq[rd_idx];
    if (pend_vld && pend_idx == rd_idx) begin
      rd_seen = 1'b1;
      rd_seq  = pend_seq;
    end
  end

endmodule

// File: rtl/noc_sink_checker.sv
// Receive-side NoC PE: accepts ejected flits under a programmable backpressure pattern and
// checks destination, source legality and per-source sequence order.
module noc_sink_checker
  import noc_pkt_pkg::*;
#(
  parameter int xcord          = 0,
  parameter int ycord          = 0,
  parameter int data_width     = DATA_W,
  parameter int X              = 4,
  parameter int Y              = 4,
  parameter int dest_x         = DEST_X_W,
  parameter int dest_y         = DEST_Y_W,
  parameter int source_x       = SOURCE_X_W,
  parameter int source_y       = SOURCE_Y_W,
  parameter int total_width    = dest_x + dest_y + source_x + source_y + data_width,
  parameter int expected_pckts = 3,
  parameter int ready_rate     = 1,
  parameter int seq_width      = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [total_width-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [31:0]            o_rx_count,
  output logic                   o_err_dest,
  output logic                   o_err_src,
  output logic                   o_err_order,
  output logic                   o_err_over,
  output logic [15:0]            o_err_count,
  output logic                   o_done
);

  localparam int dst_y_lsb   = dest_x;
  localparam int src_x_lsb   = dst_y_lsb + dest_y;
  localparam int src_y_lsb   = src_x_lsb + source_x;
  localparam int payload_lsb = src_y_lsb + source_y;
  localparam int entries     = X * Y;
  localparam int idx_w       = (entries > 1) ? $clog2(entries) : 1;
  localparam int ph_w        = (ready_rate > 1) ? $clog2(ready_rate) : 1;

  logic [ph_w-1:0] phase, phase_nxt;

  always_comb begin
    phase_nxt = '0;
    if (ready_rate > 1 && phase != ph_w'(ready_rate - 1)) phase_nxt = phase + ph_w'(1);
  end

  // o_ready is registered from the next phase so it lines up with the phase it describes
  always_ff @(posedge clk) begin
    if (!rstn) begin
      phase   <= '0;
      o_ready <= 1'b1;
    end else begin
      phase   <= phase_nxt;
      o_ready <= !(ready_rate > 1 && phase_nxt == ph_w'(ready_rate - 1));
    end
  end

  logic [dest_x-1:0]    fld_dst_x;
  logic [dest_y-1:0]    fld_dst_y;
  logic [source_x-1:0]  fld_src_x;
  logic [source_y-1:0]  fld_src_y;
  logic [seq_width-1:0] seq;

  assign fld_dst_x = i_data[dst_y_lsb-1:0];
  assign fld_dst_y = i_data[src_x_lsb-1:dst_y_lsb];
  assign fld_src_x = i_data[src_y_lsb-1:src_x_lsb];
  assign fld_src_y = i_data[payload_lsb-1:src_y_lsb];
  assign seq       = i_data[payload_lsb +: seq_width];

  if (data_width > seq_width) begin : g_unused
    logic unused_payload;
    assign unused_payload = ^i_data[total_width-1:payload_lsb+seq_width];
  end

  logic             accept, src_ok, rd_seen;
  logic [idx_w-1:0] idx;
  logic [seq_width-1:0] rd_seq;
  logic             e_dest, e_src, e_order, e_over;
  logic [2:0]       err_inc;
  logic [16:0]      err_sum;

  assign accept = i_valid & o_ready;
  assign src_ok = (int'(fld_src_x) < X) && (int'(fld_src_y) < Y);
  assign idx    = src_ok ? idx_w'(src_index(fld_src_x, fld_src_y, X)) : '0;

  noc_seq_scoreboard #(
    .entries  (entries),
    .idx_w    (idx_w),
    .seq_width(seq_width)
  ) u_scoreboard (
    .clk    (clk),
    .rstn   (rstn),
    .rd_idx (idx),
    .rd_seen(rd_seen),
    .rd_seq (rd_seq),
    .wr_en  (accept & src_ok),
    .wr_idx (idx),
    .wr_seq (seq)
  );

  assign e_dest  = accept && (int'(fld_dst_x) != xcord || int'(fld_dst_y) != ycord);
  assign e_src   = accept && !src_ok;
  assign e_order = accept && src_ok && rd_seen && (seq <= rd_seq);
  assign e_over  = accept && o_done;
  assign err_inc = 3'(e_dest) + 3'(e_src) + 3'(e_order) + 3'(e_over);
  assign err_sum = 17'(o_err_count) + 17'(err_inc);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_rx_count  <= '0;
      o_err_dest  <= 1'b0;
      o_err_src   <= 1'b0;
      o_err_order <= 1'b0;
      o_err_over  <= 1'b0;
      o_err_count <= '0;
    end else begin
      if (accept && o_rx_count != '1) o_rx_count <= o_rx_count + 32'd1;
      o_err_dest  <= o_err_dest  | e_dest;
      o_err_src   <= o_err_src   | e_src;
      o_err_order <= o_err_order | e_order;
      o_err_over  <= o_err_over  | e_over;
      o_err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign o_done = (o_rx_count == 32'(expected_pckts));

endmodule

// File: tb/tb_noc_sink_checker.sv
// Scoreboard bench: stimulus queues the hand-computed status expected after each accept,
// a monitor pops and compares on the cycle following every accepting edge.
module tb_noc_sink_checker;
  import noc_pkt_pkg::*;

  localparam int TW = TOTAL_W;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // u_dut: node (1,2), always ready; u_bp: node (0,0), ready_rate 4
  logic [TW-1:0] a_data, b_data;
  logic a_valid, b_valid, a_ready, b_ready;
  logic [31:0] a_rx, b_rx;
  logic a_dest, a_src, a_order, a_over, a_done;
  logic b_dest, b_src, b_order, b_over, b_done;
  logic [15:0] a_ecnt, b_ecnt;

  noc_sink_checker #(.xcord(1), .ycord(2), .ready_rate(1), .expected_pckts(3)) u_dut (
    .clk(clk), .rstn(rstn), .i_data(a_data), .i_valid(a_valid), .o_ready(a_ready),
    .o_rx_count(a_rx), .o_err_dest(a_dest), .o_err_src(a_src), .o_err_order(a_order),
    .o_err_over(a_over), .o_err_count(a_ecnt), .o_done(a_done));

  noc_sink_checker #(.xcord(0), .ycord(0), .ready_rate(4), .expected_pckts(100)) u_bp (
    .clk(clk), .rstn(rstn), .i_data(b_data), .i_valid(b_valid), .o_ready(b_ready),
    .o_rx_count(b_rx), .o_err_dest(b_dest), .o_err_src(b_src), .o_err_order(b_order),
    .o_err_over(b_over), .o_err_count(b_ecnt), .o_done(b_done));

  typedef struct packed {
    logic [31:0] rx;
    logic        dest, src, order, over;
    logic [15:0] ecnt;
    logic        done;
  } status_t;

  status_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int n_mon = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [TW-1:0] mk(input int dx, input int dy, input int sx, input int sy,
                                       input logic [31:0] seq);
    logic [TW-1:0] d;
    d = '0;
    d[DST_X_LSB +: DEST_X_W]   = DEST_X_W'(dx);
    d[DST_Y_LSB +: DEST_Y_W]   = DEST_Y_W'(dy);
    d[SRC_X_LSB +: SOURCE_X_W] = SOURCE_X_W'(sx);
    d[SRC_Y_LSB +: SOURCE_Y_W] = SOURCE_Y_W'(sy);
    d[PAYLOAD_LSB +: 32]       = seq;
    d[PAYLOAD_LSB + 32 +: 8]   = 8'hA5;
    return d;
  endfunction

  function automatic status_t st(input int rx, input logic de, input logic sr, input logic od,
                                 input logic ov, input int ec, input logic dn);
    status_t s;
    s.rx = 32'(rx); s.dest = de; s.src = sr; s.order = od; s.over = ov;
    s.ecnt = 16'(ec); s.done = dn;
    return s;
  endfunction

  // Monitor: an accept at a posedge is checked on the following negedge
  logic acc_q = 1'b0;
  always @(posedge clk) acc_q <= rstn && a_valid && a_ready;

  always @(negedge clk) begin
    if (acc_q) begin
      status_t act, e;
      act = {a_rx, a_dest, a_src, a_order, a_over, a_ecnt, a_done};
      n_mon++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_accept: accept %0d seen with no queued status %0h", n_mon, act);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("status_after_accept_%0d", n_mon), 64'(act), 64'(e));
      end
    end
  end

  task automatic send(input int dx, input int dy, input int sx, input int sy,
                      input logic [31:0] seq, input status_t e);
    @(posedge clk); #1;
    check("a_ready_high", 64'(a_ready), 64'd1);
    a_valid = 1'b1;
    a_data  = mk(dx, dy, sx, sy, seq);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_rx"},    64'(a_rx),    64'd0);
    check({tag, "_flags"}, 64'({a_dest, a_src, a_order, a_over}), 64'd0);
    check({tag, "_ecnt"},  64'(a_ecnt),  64'd0);
    check({tag, "_done"},  64'(a_done),  64'd0);
    check({tag, "_ready"}, 64'(a_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_a_reset("reset");
    check("bp_reset_rx", 64'(b_rx), 64'd0);
    check("bp_reset_ready", 64'(b_ready), 64'd1);

    // In-order stream from (0,0): counts 1,2,3, done after the third
    send(1, 2, 0, 0, 0, st(1, 0, 0, 0, 0, 0, 0));
    send(1, 2, 0, 0, 1, st(2, 0, 0, 0, 0, 0, 0));
    send(1, 2, 0, 0, 2, st(3, 0, 0, 0, 0, 0, 1));
    idle();

    // Misrouted flit
    do_reset();
    send(0, 0, 0, 0, 0, st(1, 1, 0, 0, 0, 1, 0));
    idle();

    // Duplicate seq back-to-back (forwarding), interleaved source, then a lower seq plus overflow
    do_reset();
    send(1, 2, 3, 1, 5, st(1, 0, 0, 0, 0, 0, 0));
    send(1, 2, 3, 1, 5, st(2, 0, 0, 1, 0, 1, 0));
    send(1, 2, 2, 1, 0, st(3, 0, 0, 1, 0, 1, 1));
    send(1, 2, 3, 1, 4, st(4, 0, 0, 1, 1, 3, 0));
    idle();

    // Illegal src_x must not touch entry 4, which belongs to (0,1)
    do_reset();
    send(1, 2, 4, 0, 0, st(1, 0, 1, 0, 0, 1, 0));
    send(1, 2, 0, 1, 0, st(2, 0, 1, 0, 0, 1, 0));
    idle();

    // Overflow past expected count, then reset with a flit presented on the reset edge
    do_reset();
    send(1, 2, 1, 1, 10, st(1, 0, 0, 0, 0, 0, 0));
    send(1, 2, 1, 1, 11, st(2, 0, 0, 0, 0, 0, 0));
    send(1, 2, 1, 1, 12, st(3, 0, 0, 0, 0, 0, 1));
    send(1, 2, 1, 1, 13, st(4, 0, 0, 0, 1, 1, 0));
    @(posedge clk); #1;
    rstn = 1'b0;
    a_data = mk(1, 2, 1, 1, 14);
    @(posedge clk); #1;
    rstn = 1'b1;
    a_valid = 1'b0;
    @(negedge clk);
    check_a_reset("midstream_reset");

    // Backpressure: valid held 8 cycles from the first ready cycle after reset
    do_reset();
    lows = 0;
    b_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b_data = mk(0, 0, 0, 0, 32'(k));
      @(negedge clk);
      check($sformatf("bp_ready_cycle_%0d", k), 64'(b_ready), (k % 4 == 3) ? 64'd0 : 64'd1);
      if (!b_ready) lows++;
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    @(negedge clk);
    check("bp_low_cycles", 64'(lows), 64'd2);
    check("bp_accept_count", 64'(b_rx), 64'd6);
    check("bp_no_order_err", 64'(b_order), 64'd0);

    repeat (2) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
